// File: rtl/sd_blk_seq_if.sv
// rtl/sd_blk_seq_if.sv - byte-exchange handshake between the sequencer and the SPI byte engine
interface sd_blk_seq_if;
   logic       spi_start;
   logic [7:0] spi_tx;
   logic [7:0] spi_rx;
   logic       spi_done;

   modport master (output spi_start, output spi_tx, input spi_rx, input spi_done);
   modport slave  (input spi_start, input spi_tx, output spi_rx, output spi_done);
endinterface

// File: rtl/sd_blk_seq.sv
// rtl/sd_blk_seq.sv - SD SPI-mode init and single-block read/write sequencer
module sd_blk_seq #(
   parameter int BLOCK_BYTES  = 512,
   parameter int INIT_BYTES   = 10,
   parameter int POLL_LIMIT   = 4096,
   parameter int ACMD41_TRIES = 1000
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         init_req,
   input  logic         rd_req,
   input  logic         wr_req,
   input  logic [31:0]  blk_addr,
   output logic         ready,
   output logic         busy,
   output logic [2:0]   error,
   output logic         err_flag,
   output logic [7:0]   rd_data,
   output logic         rd_valid,
   input  logic [7:0]   wr_data,
   output logic         wr_take,
   output logic         cs_n,
   sd_blk_seq_if.master spi
);

   typedef enum logic [3:0] {
      S_IDLE, S_PWRUP, S_CMD, S_R1, S_R7, S_TOKEN, S_RDDATA, S_RDCRC,
      S_WRPRE, S_WRDATA, S_WRCRC, S_WRRESP, S_WRBUSY, S_TRAIL, S_READY, S_ERR
   } state_t;

   // Each byte: LOAD latches the outgoing byte, START pulses spi_start, WAIT holds for spi_done.
   typedef enum logic [1:0] {PH_LOAD, PH_START, PH_WAIT} phase_t;

   localparam logic [9:0]  LAST_INIT = 10'(INIT_BYTES - 1);
   localparam logic [9:0]  LAST_DATA = 10'(BLOCK_BYTES - 1);
   localparam logic [12:0] LAST_POLL = 13'(POLL_LIMIT - 1);
   localparam logic [9:0]  LAST_TRY  = 10'(ACMD41_TRIES - 1);

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [9:0]  byte_cnt_q, byte_cnt_d;
   logic [12:0] poll_cnt_q, poll_cnt_d;
   logic [9:0]  tries_q, tries_d;
   logic [5:0]  cmd_q, cmd_d;
   logic [31:0] arg_q, arg_d;
   logic [7:0]  tx_q, tx_d;
   logic [2:0]  error_q, error_d;
   logic        err_flag_q, err_flag_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        cs_n_q, cs_n_d;

   logic        byte_state, byte_done, spi_start_c, go_cmd;
   logic [5:0]  go_idx;
   logic [31:0] go_arg;
   logic [2:0]  err_code;
   logic [7:0]  tx_byte, rx;

   assign rx         = spi.spi_rx;
   assign byte_state = !(state_q inside {S_IDLE, S_READY, S_ERR});

   // Next-state, byte handshake and command sequencing.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      byte_cnt_d  = byte_cnt_q;
      poll_cnt_d  = poll_cnt_q;
      tries_d     = tries_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      tx_d        = tx_q;
      error_d     = error_q;
      err_flag_d  = err_flag_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      wr_take     = 1'b0;
      spi_start_c = 1'b0;
      byte_done   = 1'b0;
      go_cmd      = 1'b0;
      go_idx      = 6'd0;
      go_arg      = 32'd0;
      err_code    = 3'd0;
      tx_byte     = 8'hFF;

      case (state_q)
         S_CMD: begin
            case (byte_cnt_q)
               10'd1:   tx_byte = {2'b01, cmd_q};
               10'd2:   tx_byte = arg_q[31:24];
               10'd3:   tx_byte = arg_q[23:16];
               10'd4:   tx_byte = arg_q[15:8];
               10'd5:   tx_byte = arg_q[7:0];
               10'd6:   tx_byte = (cmd_q == 6'd0) ? 8'h95 : (cmd_q == 6'd8) ? 8'h87 : 8'h01;
               default: tx_byte = 8'hFF;
            endcase
         end
         S_WRPRE: tx_byte = (byte_cnt_q == 10'd0) ? 8'hFF : 8'hFE;
         default: tx_byte = 8'hFF;
      endcase

      if (byte_state) begin
         case (phase_q)
            PH_LOAD: begin
               if (state_q == S_WRDATA) begin
                  wr_take = 1'b1;
                  tx_d    = wr_data;
               end else begin
                  tx_d    = tx_byte;
               end
               phase_d = PH_START;
            end
            PH_START: begin
               spi_start_c = 1'b1;
               phase_d     = PH_WAIT;
            end
            default: begin
               if (spi.spi_done) begin
                  byte_done = 1'b1;
                  phase_d   = PH_LOAD;
               end
            end
         endcase
      end

      case (state_q)
         S_IDLE, S_READY, S_ERR: begin
            if (init_req) begin
               state_d    = S_PWRUP;
               err_flag_d = 1'b0;
               error_d    = 3'd0;
               tries_d    = 10'd0;
            end else if (state_q == S_READY && (rd_req || wr_req)) begin
               go_cmd = 1'b1;
               go_idx = rd_req ? 6'd17 : 6'd24;
               go_arg = blk_addr;
            end
         end
         S_PWRUP: if (byte_done) begin
            if (byte_cnt_q == LAST_INIT) go_cmd = 1'b1;
            else byte_cnt_d = byte_cnt_q + 10'd1;
         end
         S_CMD: if (byte_done) begin
            if (byte_cnt_q == 10'd6) state_d = S_R1;
            else byte_cnt_d = byte_cnt_q + 10'd1;
         end
         S_R1: if (byte_done) begin
            if (!rx[7]) begin
               case (cmd_q)
                  6'd0: begin
                     if (rx == 8'h01) begin
                        go_cmd = 1'b1;
                        go_idx = 6'd8;
                        go_arg = 32'h0000_01AA;
                     end else err_code = 3'd2;
                  end
                  6'd8: begin
                     if (rx == 8'h01) state_d = S_R7;
                     else err_code = 3'd2;
                  end
                  6'd55: begin
                     if (rx == 8'h01 || rx == 8'h00) begin
                        go_cmd = 1'b1;
                        go_idx = 6'd41;
                        go_arg = 32'h4000_0000;
                     end else err_code = 3'd2;
                  end
                  6'd41: begin
                     if (rx == 8'h00) state_d = S_TRAIL;
                     else if (rx != 8'h01) err_code = 3'd2;
                     else if (tries_q == LAST_TRY) err_code = 3'd6;
                     else begin
                        tries_d = tries_q + 10'd1;
                        go_cmd  = 1'b1;
                        go_idx  = 6'd55;
                     end
                  end
                  6'd17: begin
                     if (rx == 8'h00) state_d = S_TOKEN;
                     else err_code = 3'd2;
                  end
                  default: begin
                     if (rx == 8'h00) state_d = S_WRPRE;
                     else err_code = 3'd2;
                  end
               endcase
            end else if (poll_cnt_q == LAST_POLL) err_code = 3'd1;
            else poll_cnt_d = poll_cnt_q + 13'd1;
         end
         S_R7: if (byte_done) begin
            if (byte_cnt_q != 10'd3) byte_cnt_d = byte_cnt_q + 10'd1;
            else if (rx == 8'hAA) begin
               go_cmd = 1'b1;
               go_idx = 6'd55;
            end else err_code = 3'd7;
         end
         S_TOKEN: if (byte_done) begin
            if (rx == 8'hFE) state_d = S_RDDATA;
            else if (rx[7:4] == 4'h0 || poll_cnt_q == LAST_POLL) err_code = 3'd3;
            else poll_cnt_d = poll_cnt_q + 13'd1;
         end
         S_RDDATA: if (byte_done) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rx;
            if (byte_cnt_q == LAST_DATA) state_d = S_RDCRC;
            else byte_cnt_d = byte_cnt_q + 10'd1;
         end
         S_RDCRC, S_WRPRE, S_WRCRC: if (byte_done) begin
            if (byte_cnt_q == 10'd1)
               state_d = (state_q == S_RDCRC) ? S_TRAIL : (state_q == S_WRPRE) ? S_WRDATA : S_WRRESP;
            else byte_cnt_d = byte_cnt_q + 10'd1;
         end
         S_WRDATA: if (byte_done) begin
            if (byte_cnt_q == LAST_DATA) state_d = S_WRCRC;
            else byte_cnt_d = byte_cnt_q + 10'd1;
         end
         S_WRRESP: if (byte_done) begin
            if (rx[4:0] == 5'h05) state_d = S_WRBUSY;
            else err_code = 3'd4;
         end
         S_WRBUSY: if (byte_done) begin
            if (rx == 8'hFF) state_d = S_TRAIL;
            else if (poll_cnt_q == LAST_POLL) err_code = 3'd5;
            else poll_cnt_d = poll_cnt_q + 13'd1;
         end
         S_TRAIL: if (byte_done) state_d = S_READY;
         default: state_d = S_IDLE;
      endcase

      if (go_cmd) begin
         state_d = S_CMD;
         cmd_d   = go_idx;
         arg_d   = go_arg;
      end
      if (err_code != 3'd0) begin
         state_d    = S_ERR;
         error_d    = err_code;
         err_flag_d = 1'b1;
      end
      cs_n_d = state_d inside {S_IDLE, S_PWRUP, S_TRAIL, S_READY, S_ERR};
   end

   // State and datapath registers; per-state counters restart whenever the state changes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         phase_q    <= PH_LOAD;
         byte_cnt_q <= '0;
         poll_cnt_q <= '0;
         tries_q    <= '0;
         cmd_q      <= '0;
         arg_q      <= '0;
         tx_q       <= 8'hFF;
         error_q    <= '0;
         err_flag_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         tries_q    <= tries_d;
         cmd_q      <= cmd_d;
         arg_q      <= arg_d;
         tx_q       <= tx_d;
         error_q    <= error_d;
         err_flag_q <= err_flag_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         cs_n_q     <= cs_n_d;
         if (state_d != state_q) begin
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
         end else begin
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
         end
      end
   end

   assign ready         = (state_q == S_READY);
   assign busy          = byte_state;
   assign error         = error_q;
   assign err_flag      = err_flag_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign cs_n          = cs_n_q;
   assign spi.spi_start = spi_start_c;
   assign spi.spi_tx    = tx_q;

endmodule

// File: tb/tb_sd_blk_seq.sv
// tb/tb_sd_blk_seq.sv - self-checking bench for sd_blk_seq against a behavioural SDHC card
`timescale 1ns/1ps
module tb_sd_blk_seq;

   logic        clk = 1'b0;
   logic        resetn, init_req, rd_req, wr_req;
   logic [31:0] blk_addr;
   logic        ready, busy, err_flag, rd_valid, wr_take, cs_n;
   logic [2:0]  error;
   logic [7:0]  rd_data, wr_data;

   always #5 clk = ~clk;

   sd_blk_seq_if sif();

   sd_blk_seq dut (
      .clk(clk), .resetn(resetn), .init_req(init_req), .rd_req(rd_req), .wr_req(wr_req),
      .blk_addr(blk_addr), .ready(ready), .busy(busy), .error(error), .err_flag(err_flag),
      .rd_data(rd_data), .rd_valid(rd_valid), .wr_data(wr_data), .wr_take(wr_take),
      .cs_n(cs_n), .spi(sif.master)
   );

   int tests = 0;
   int fails = 0;

   // card model state
   logic [7:0]  mem [16][512];
   logic [7:0]  rq[$];
   logic [47:0] fr_sh;
   int          fr_n = 0;
   bit          in_frame = 0;
   int          wr_st = 0, wcnt = 0, waddr = 0;
   logic [47:0] frames_q[$];
   logic [7:0]  crc_q[$];
   int          cs_hi_cnt = 0, hi_bad = 0, ex_cnt = 0, acmd_left = 0;
   bit          no_r1 = 0, bad_token = 0;

   // scoreboard
   logic [47:0] exp_fr[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [7:0]  wpat [512];

   function automatic logic [7:0] sec_byte(input int b, input int i);
      return 8'((b * 37) + (i * 5) + (i >> 8));
   endfunction

   task automatic respond(input logic [47:0] f);
      logic [5:0]  idx;
      logic [31:0] arg;
      idx = f[45:40];
      arg = f[39:8];
      if (no_r1) return;
      rq.push_back(8'hFF);
      case (idx)
         6'd0:  begin rq.push_back(8'h01); acmd_left = 2; end
         6'd8:  begin rq.push_back(8'h01); rq.push_back(8'h00); rq.push_back(8'h00); rq.push_back(8'h01); rq.push_back(8'hAA); end
         6'd55: rq.push_back(acmd_left > 0 ? 8'h01 : 8'h00);
         6'd41: begin
            if (acmd_left > 0) begin rq.push_back(8'h01); acmd_left--; end
            else rq.push_back(8'h00);
         end
         6'd17: begin
            rq.push_back(8'h00); rq.push_back(8'hFF); rq.push_back(8'hFF);
            if (bad_token) rq.push_back(8'h08);
            else begin
               rq.push_back(8'hFE);
               for (int i = 0; i < 512; i++) rq.push_back(mem[arg[3:0]][i]);
               rq.push_back(8'h12); rq.push_back(8'h34);
            end
         end
         6'd24: begin rq.push_back(8'h00); wr_st = 1; waddr = int'(arg[3:0]); end
         default: rq.push_back(8'h04);
      endcase
   endtask

   task automatic model_xchg(input logic [7:0] tx, input logic csn, output logic [7:0] rx);
      rx = 8'hFF;
      if (csn) begin
         cs_hi_cnt++;
         if (tx !== 8'hFF) hi_bad++;
         rq.delete(); in_frame = 0; wr_st = 0;
         return;
      end
      ex_cnt++;
      if (rq.size() > 0) rx = rq.pop_front();
      if (wr_st == 1) begin
         if (tx == 8'hFE) begin wr_st = 2; wcnt = 0; end
      end else if (wr_st == 2) begin
         mem[waddr][wcnt] = tx;
         wcnt++;
         if (wcnt == 512) begin wr_st = 3; wcnt = 0; end
      end else if (wr_st == 3) begin
         crc_q.push_back(tx);
         wcnt++;
         if (wcnt == 2) begin
            wr_st = 0;
            rq.push_back(8'hE5); rq.push_back(8'h00); rq.push_back(8'h00); rq.push_back(8'h00); rq.push_back(8'hFF);
         end
      end else if (in_frame) begin
         fr_sh = {fr_sh[39:0], tx};
         fr_n++;
         if (fr_n == 6) begin
            in_frame = 0;
            frames_q.push_back(fr_sh);
            ex_cnt = 0;
            respond(fr_sh);
         end
      end else if (tx[7:6] == 2'b01) begin
         in_frame = 1;
         fr_sh = {40'd0, tx};
         fr_n = 1;
      end
   endtask

   // SPI byte engine plus card: answers each spi_start two cycles later with a one-cycle spi_done
   initial begin
      logic [7:0] rx_b;
      for (int b = 0; b < 16; b++)
         for (int i = 0; i < 512; i++) mem[b][i] = sec_byte(b, i);
      sif.spi_rx   = 8'hFF;
      sif.spi_done = 1'b0;
      forever begin
         @(negedge clk);
         if (sif.spi_start === 1'b1) begin
            model_xchg(sif.spi_tx, cs_n, rx_b);
            repeat (2) @(negedge clk);
            sif.spi_rx   = rx_b;
            sif.spi_done = 1'b1;
            @(negedge clk);
            sif.spi_done = 1'b0;
         end
      end
   end

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (ready || err_flag) begin ok = 1; break; end
      end
   endtask

   task automatic pulse_init();
      @(negedge clk); init_req = 1'b1;
      @(negedge clk); init_req = 1'b0;
   endtask

   task automatic do_read(input int blk, input bit also_wr, output bit ok);
      blk_addr = 32'(blk);
      got_q.delete();
      ok = 0;
      @(negedge clk); rd_req = 1'b1; wr_req = also_wr;
      @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (rd_valid) got_q.push_back(rd_data);
         if (ready) begin ok = 1; break; end
         if (err_flag) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({ready, busy, err_flag, error} !== 6'b0) begin
         fails++; $display("FAIL reset_status: got %b want 000000", {ready, busy, err_flag, error});
      end
      tests++;
      if ({rd_valid, wr_take, sif.spi_start, sif.spi_tx, cs_n} !== 12'b000_11111111_1) begin
         fails++; $display("FAIL reset_datapath: got %b want 000111111111", {rd_valid, wr_take, sif.spi_start, sif.spi_tx, cs_n});
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_init();
      bit          ok;
      logic [47:0] e, g;
      frames_q.delete(); exp_fr.delete();
      cs_hi_cnt = 0; hi_bad = 0;
      exp_fr.push_back(48'h400000000095);
      exp_fr.push_back(48'h48000001AA87);
      for (int i = 0; i < 3; i++) begin
         exp_fr.push_back(48'h770000000001);
         exp_fr.push_back(48'h694000000001);
      end
      pulse_init();
      tests++;
      if ({busy, ready} !== 2'b10) begin fails++; $display("FAIL init_busy: got %b want 10", {busy, ready}); end
      wait_done(5000, ok);
      tests++;
      if (!ok || {ready, busy, err_flag, error, cs_n} !== 7'b1000001) begin
         fails++; $display("FAIL init_ready: got %b want 1000001", {ready, busy, err_flag, error, cs_n});
      end
      tests++;
      if (frames_q.size() != exp_fr.size()) begin
         fails++; $display("FAIL init_frame_count: got %0d want %0d", frames_q.size(), exp_fr.size());
      end
      while (exp_fr.size() > 0) begin
         e = exp_fr.pop_front();
         if (frames_q.size() > 0) g = frames_q.pop_front();
         else g = 48'hx;
         tests++;
         if (g !== e) begin fails++; $display("FAIL init_frame: got %h want %h", g, e); end
      end
      tests++;
      if (cs_hi_cnt != 11 || hi_bad != 0) begin
         fails++; $display("FAIL init_cs_high_bytes: got %0d (non-FF %0d) want 11 (0)", cs_hi_cnt, hi_bad);
      end
   endtask

   task automatic test_read();
      bit         ok;
      logic [7:0] e, g;
      frames_q.delete(); exp_q.delete();
      for (int i = 0; i < 512; i++) exp_q.push_back(sec_byte(5, i));
      do_read(5, 1'b0, ok);
      tests++;
      if (!ok || err_flag !== 1'b0) begin fails++; $display("FAIL read_done: ready %b err %0d want ready", ready, error); end
      tests++;
      if (frames_q.size() != 1 || frames_q[0] !== 48'h510000000501) begin
         fails++; $display("FAIL read_frame: got %0d frames first %h want 1 x 510000000501", frames_q.size(), frames_q.size() > 0 ? frames_q[0] : 48'h0);
      end
      tests++;
      if (got_q.size() != 512) begin fails++; $display("FAIL read_strobes: got %0d want 512", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         tests++;
         if (g !== e) begin fails++; $display("FAIL read_byte %0d: got %h want %h", 511 - exp_q.size(), g, e); end
      end
   endtask

   task automatic test_write();
      bit         ok;
      int         takes, widx;
      logic [7:0] e, g;
      frames_q.delete(); crc_q.delete(); exp_q.delete();
      for (int i = 0; i < 512; i++) wpat[i] = 8'($urandom);
      takes = 0; widx = 0; ok = 0;
      blk_addr = 32'd7;
      @(negedge clk); wr_req = 1'b1;
      @(negedge clk); wr_req = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (wr_take) begin
            takes++;
            wr_data = wpat[widx];
            if (widx < 511) widx++;
         end
         if (ready) begin ok = 1; break; end
         if (err_flag) break;
         @(negedge clk);
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL write_done: ready %b err %0d want ready", ready, error); end
      tests++;
      if (takes != 512) begin fails++; $display("FAIL write_takes: got %0d want 512", takes); end
      tests++;
      if (frames_q.size() != 1 || frames_q[0] !== 48'h580000000701) begin
         fails++; $display("FAIL write_frame: got %0d frames first %h want 1 x 580000000701", frames_q.size(), frames_q.size() > 0 ? frames_q[0] : 48'h0);
      end
      tests++;
      if (crc_q.size() != 2 || crc_q[0] !== 8'hFF || crc_q[1] !== 8'hFF) begin
         fails++; $display("FAIL write_crc: got %0d bytes want FF FF", crc_q.size());
      end
      for (int i = 0; i < 512; i++) exp_q.push_back(wpat[i]);
      do_read(7, 1'b0, ok);
      tests++;
      if (!ok || got_q.size() != 512) begin fails++; $display("FAIL readback_strobes: got %0d want 512", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         tests++;
         if (g !== e) begin fails++; $display("FAIL readback_byte %0d: got %h want %h", 511 - exp_q.size(), g, e); end
      end
   endtask

   task automatic test_same_cycle();
      bit ok;
      frames_q.delete();
      do_read(5, 1'b1, ok);
      tests++;
      if (!ok || frames_q.size() != 1 || frames_q[0] !== 48'h510000000501) begin
         fails++; $display("FAIL same_cycle_frame: got %0d frames first %h want 1 x 510000000501", frames_q.size(), frames_q.size() > 0 ? frames_q[0] : 48'h0);
      end
      tests++;
      if (got_q.size() != 512 || got_q[0] !== sec_byte(5, 0) || got_q[511] !== sec_byte(5, 511)) begin
         fails++; $display("FAIL same_cycle_data: got %0d bytes want 512 of sector 5", got_q.size());
      end
   endtask

   task automatic test_bad_token();
      bit ok;
      bad_token = 1;
      do_read(5, 1'b0, ok);
      tests++;
      if ({err_flag, error, cs_n, busy, ready} !== 7'b1011100) begin
         fails++; $display("FAIL bad_token_err: got %b want 1011100", {err_flag, error, cs_n, busy, ready});
      end
      bad_token = 0;
      frames_q.delete();
      blk_addr = 32'd5;
      @(negedge clk); rd_req = 1'b1;
      @(negedge clk); rd_req = 1'b0;
      repeat (20) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || frames_q.size() != 0) begin
         fails++; $display("FAIL err_ignores_rd: busy %b frames %0d want 0 0", busy, frames_q.size());
      end
      pulse_init();
      wait_done(5000, ok);
      tests++;
      if (!ok || {ready, err_flag, error} !== 5'b10000) begin
         fails++; $display("FAIL bad_token_recover: got %b want 10000", {ready, err_flag, error});
      end
   endtask

   task automatic test_r1_timeout();
      bit ok;
      no_r1 = 1;
      pulse_init();
      wait_done(40000, ok);
      tests++;
      if (!ok || {err_flag, error, cs_n, busy, ready} !== 7'b1001100) begin
         fails++; $display("FAIL r1_timeout_err: got %b want 1001100", {err_flag, error, cs_n, busy, ready});
      end
      tests++;
      if (ex_cnt != 4096) begin fails++; $display("FAIL r1_timeout_polls: got %0d want 4096", ex_cnt); end
      no_r1 = 0;
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      int seen;
      pulse_init();
      wait_done(5000, ok);
      tests++;
      if (!ok || ready !== 1'b1) begin fails++; $display("FAIL mid_read_preinit: ready %b want 1", ready); end
      blk_addr = 32'd5;
      @(negedge clk); rd_req = 1'b1;
      @(negedge clk); rd_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 5000 && seen < 100; i++) begin
         @(negedge clk);
         if (rd_valid) seen++;
      end
      tests++;
      if (seen != 100) begin fails++; $display("FAIL mid_read_progress: got %0d strobes want 100", seen); end
      resetn = 1'b0;
      #1;
      tests++;
      if ({cs_n, rd_valid, ready, busy, sif.spi_start} !== 5'b10000) begin
         fails++; $display("FAIL mid_read_reset: got %b want 10000", {cs_n, rd_valid, ready, busy, sif.spi_start});
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      pulse_init();
      wait_done(5000, ok);
      tests++;
      if (!ok || {ready, err_flag} !== 2'b10) begin fails++; $display("FAIL mid_read_reinit: got %b want 10", {ready, err_flag}); end
   endtask

   initial begin
      resetn = 1'b0; init_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      blk_addr = 32'd0; wr_data = 8'h00;
      test_reset();
      test_init();
      test_read();
      test_write();
      test_same_cycle();
      test_bad_token();
      test_r1_timeout();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
